// File: rtl/wbq_pkg.sv
// Shared widths, depth and entry layout for the writeback queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wbq_pkg;

   localparam int WBQ_ADDR_W = 5;    // register address width
   localparam int WBQ_DATA_W = 32;   // register data width
   localparam int WBQ_DEPTH  = 4;    // queue entries, power of two, >= 2

   // One pending register-file write at the default widths. The queue
   // declares an identically laid-out struct sized by its own parameters.
   typedef struct packed {
      logic [WBQ_ADDR_W-1:0] addr;
      logic [WBQ_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the pending writes, used for operand forwarding.
// Latency: combinational.
// Backpressure: none; pure lookup, never stalls the queue.
//
// Ports:
//   i_addr/i_data/i_vld : entries ordered by age, index 0 oldest
//   i_lk_addr           : address being looked up (0 never hits)
//   o_hit/o_data        : match flag and data of the youngest matching entry
module wbq_lookup #(
   parameter int addWidth  = 5,
   parameter int dataWidth = 32,
   parameter int DEPTH     = 4
) (
   input  logic [DEPTH-1:0][addWidth-1:0]  i_addr,
   input  logic [DEPTH-1:0][dataWidth-1:0] i_data,
   input  logic [DEPTH-1:0]                i_vld,
   input  logic [addWidth-1:0]             i_lk_addr,
   output logic                            o_hit,
   output logic [dataWidth-1:0]            o_data
);

   // Scan oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_vld[i] && (i_addr[i] == i_lk_addr) && (i_lk_addr != '0)) begin
            o_hit  = 1'b1;
            o_data = i_data[i];
         end
      end
   end

endmodule

// File: rtl/wb_queue.sv
// Secondary writeback queue: buffers (addr,data) writes until the shared register-file port is free.
// Latency: push to we3 is 1 cycle minimum; one write drains per cycle port_busy is low.
// Backpressure: in_ready low while full, including a cycle that pops while full.
//
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_addr/in_data : producer write requests (addr 0 is accepted and dropped)
//   port_busy                     : primary writeback owns the write port this cycle
//   we3/addr_3/data_in_3          : register-file write port driven from the queue head
//   lk_addr/lk_hit/lk_data        : forwarding lookup, present only when WBQ_FWD_EN is defined
//   count                         : occupied entries
module wb_queue
   import wbq_pkg::*;
#(
   parameter int addWidth  = WBQ_ADDR_W,
   parameter int dataWidth = WBQ_DATA_W,
   parameter int DEPTH     = WBQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [addWidth-1:0]      in_addr,
   input  logic [dataWidth-1:0]     in_data,
   input  logic                     port_busy,
   output logic                     we3,
   output logic [addWidth-1:0]      addr_3,
   output logic [dataWidth-1:0]     data_in_3,
   input  logic [addWidth-1:0]      lk_addr,
   output logic                     lk_hit,
   output logic [dataWidth-1:0]     lk_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [addWidth-1:0]  addr;
      logic [dataWidth-1:0] data;
   } entry_t;

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_push;
   logic               w_pop;
   logic               w_not_empty;

   assign w_not_empty = (r_count != '0);

   // Ready looks at occupancy only, so a full queue never reuses the slot
   // being freed in the same cycle.
   assign in_ready = (r_count < CNT_W'(DEPTH));

   // Address 0 completes the handshake but is never stored.
   assign w_push = in_valid && in_ready && (in_addr != '0);

   assign we3   = w_not_empty && !port_busy;
   assign w_pop = we3;

   assign addr_3    = w_not_empty ? r_mem[r_rd_ptr].addr : '0;
   assign data_in_3 = w_not_empty ? r_mem[r_rd_ptr].data : '0;
   assign count     = r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage needs no reset: contents are only visible through r_count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= '{addr: in_addr, data: in_data};
   end

`ifdef WBQ_FWD_EN
   logic [DEPTH-1:0][addWidth-1:0]  w_age_addr;
   logic [DEPTH-1:0][dataWidth-1:0] w_age_data;
   logic [DEPTH-1:0]                w_age_vld;

   // Present entries oldest-first so the search can favour the youngest.
   // The head being popped this cycle is still stored and still searched;
   // the request arriving this cycle is not yet stored and is excluded.
   always_comb begin
      w_age_addr = '0;
      w_age_data = '0;
      w_age_vld  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_age_addr[i] = r_mem[r_rd_ptr + PTR_W'(i)].addr;
         w_age_data[i] = r_mem[r_rd_ptr + PTR_W'(i)].data;
         w_age_vld[i]  = (CNT_W'(i) < r_count);
      end
   end

   wbq_lookup #(
      .addWidth  (addWidth),
      .dataWidth (dataWidth),
      .DEPTH     (DEPTH)
   ) u_lookup (
      .i_addr    (w_age_addr),
      .i_data    (w_age_data),
      .i_vld     (w_age_vld),
      .i_lk_addr (lk_addr),
      .o_hit     (lk_hit),
      .o_data    (lk_data)
   );
`else
   // Forwarding compiled out: lookup address is intentionally ignored.
   logic w_unused_lk;
   assign w_unused_lk = ^lk_addr;
   assign lk_hit  = 1'b0;
   assign lk_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: pending-write queue model, directed cases then random traffic.
// Latency: checks each cycle at the falling edge.
// Backpressure: model accepts only while fewer than DEPTH writes are pending.
module tb_wb_queue;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          port_busy = 1'b0;
   logic [AW-1:0] lk_addr = '0;
   logic          in_ready;
   logic          we3;
   logic [AW-1:0] addr_3;
   logic [DW-1:0] data_in_3;
   logic          lk_hit;
   logic [DW-1:0] lk_data;
   logic [2:0]    count;

   always #5 clk = ~clk;

   wb_queue #(.addWidth(AW), .dataWidth(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .port_busy (port_busy),
      .we3       (we3),
      .addr_3    (addr_3),
      .data_in_3 (data_in_3),
      .lk_addr   (lk_addr),
      .lk_hit    (lk_hit),
      .lk_data   (lk_data),
      .count     (count)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t exp_q[$];      // writes accepted but not yet issued, oldest first
   int   m_cnt  = 0;    // pending writes as of the current cycle
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Model: a request enters when capacity allows and addr is non-zero; one
   // pending write leaves every cycle the port is free.
   always @(posedge clk) begin
      if (rst_n) begin
         bit mp, mq;
         mp = in_valid && (m_cnt < DEPTH) && (in_addr != '0);
         mq = (m_cnt != 0) && !port_busy;
         if (mp) exp_q.push_back('{in_addr, in_data});
         m_cnt = m_cnt + int'(mp) - int'(mq);
      end
   end

   // Monitor: compares DUT outputs against the pending-write set each cycle.
   always @(negedge clk) begin
      if (rst_n && !done) begin
         bit            ew, eh;
         logic [DW-1:0] ld;
         ent_t          e;
         chk("count", 64'(count), 64'(m_cnt));
         chk("in_ready", 64'(in_ready), 64'(m_cnt < DEPTH));
         ew = (m_cnt != 0) && !port_busy;
         chk("we3", 64'(we3), 64'(ew));
         if (m_cnt == 0) begin
            chk("addr_3_idle", 64'(addr_3), 64'd0);
            chk("data_in_3_idle", 64'(data_in_3), 64'd0);
         end
         eh = 1'b0;
         ld = '0;
`ifdef WBQ_FWD_EN
         if (lk_addr != '0) begin
            foreach (exp_q[i]) begin
               if (exp_q[i].a == lk_addr) begin
                  eh = 1'b1;
                  ld = exp_q[i].d;
               end
            end
         end
`endif
         chk("lk_hit", 64'(lk_hit), 64'(eh));
         chk("lk_data", 64'(lk_data), 64'(ld));
         if (ew) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(addr_3), 64'(e.a));
               chk("wr_data", 64'(data_in_3), 64'(e.d));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      tick();
   endtask

   task automatic model_reset();
      m_cnt = 0;
      exp_q.delete();
   endtask

   initial begin
      // Reset values
      idle();
      repeat (2) tick();
      chk("rst_we3", 64'(we3), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_lk_hit", 64'(lk_hit), 64'd0);
      chk("rst_lk_data", 64'(lk_data), 64'd0);
      chk("rst_addr_3", 64'(addr_3), 64'd0);
      chk("rst_data_in_3", 64'(data_in_3), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single write, port free: issued the following cycle
      push(5'd5, 32'hA5A5_A5A5);
      idle();
      #1;
      chk("single_we3", 64'(we3), 64'd1);
      chk("single_addr", 64'(addr_3), 64'd5);
      chk("single_data", 64'(data_in_3), 64'hA5A5_A5A5);
      tick();
      chk("single_count", 64'(count), 64'd0);

      // Fill while port busy, then drain in order on consecutive cycles
      port_busy = 1'b1;
      for (int i = 1; i <= 4; i++) push(AW'(i), 32'h100 + 32'(i));
      idle();
      #1;
      chk("full_count", 64'(count), 64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_we3", 64'(we3), 64'd0);
      port_busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("drain_we3", 64'(we3), 64'd1);
         chk("drain_addr", 64'(addr_3), 64'(k + 1));
         chk("drain_data", 64'(data_in_3), 64'h100 + 64'(k + 1));
         tick();
      end
      chk("drain_count", 64'(count), 64'd0);

      // Address 0 is accepted and dropped
      for (int k = 0; k < 3; k++) begin
         push(5'd0, 32'hFFFF_FFFF);
         chk("zero_in_ready", 64'(in_ready), 64'd1);
         chk("zero_count", 64'(count), 64'd0);
         chk("zero_we3", 64'(we3), 64'd0);
      end
      idle();

      // Forwarding picks the youngest match; address 0 never hits
      port_busy = 1'b1;
      push(5'd7, 32'h11);
      push(5'd7, 32'h22);
      idle();
      lk_addr = 5'd7;
      #1;
`ifdef WBQ_FWD_EN
      chk("fwd_hit", 64'(lk_hit), 64'd1);
      chk("fwd_data", 64'(lk_data), 64'h22);
`else
      chk("fwd_hit_off", 64'(lk_hit), 64'd0);
      chk("fwd_data_off", 64'(lk_data), 64'd0);
`endif
      lk_addr = 5'd0;
      #1;
      chk("fwd_zero_hit", 64'(lk_hit), 64'd0);
      lk_addr = 5'd3;
      #1;
      chk("fwd_miss_hit", 64'(lk_hit), 64'd0);
      port_busy = 1'b0;
      repeat (3) tick();

      // Steady push+pop at count 3 across pointer wrap
      port_busy = 1'b1;
      for (int i = 0; i < 3; i++) push(AW'(10 + i), 32'hC000 + 32'(i));
      port_busy = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_addr  = AW'(13 + k);
         in_data  = 32'hD000 + 32'(k);
         #1;
         chk("steady_count", 64'(count), 64'd3);
         tick();
      end
      idle();
      repeat (4) tick();

      // Reset with two pending writes: cleared at once, nothing issued later
      port_busy = 1'b1;
      push(5'd20, 32'hBEEF_0001);
      push(5'd21, 32'hBEEF_0002);
      idle();
      #1;
      chk("prerst_count", 64'(count), 64'd2);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_we3", 64'(we3), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      port_busy = 1'b0;
      #1;
      chk("arst_we3_free", 64'(we3), 64'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      repeat (5) tick();

      // Random traffic with small address range to exercise forwarding
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_addr   = AW'($urandom_range(0, 7));
         in_data   = $urandom;
         port_busy = (n < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
         lk_addr   = AW'($urandom_range(0, 7));
         tick();
      end
      idle();
      port_busy = 1'b0;
      for (int n = 0; n < 20 && m_cnt != 0; n++) tick();
      #1;
      chk("final_drain", 64'(count), 64'd0);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
